noc_output_arbiter: RTL and testbench

- Packet-level arbiter sharing one router output port among NUM_REQ input FIFOs. Typical sources are the priority and regular FIFOs of several input ports.
- Picks a winner by flit class (priority head beats regular head), then round-robin within the class.
- Holds the grant from head flit to tail flit, so packets are never interleaved on the output.
- Drives the standard req/bussy output handshake and generates the per-FIFO read strobes.

---
 rtl/noc_output_arbiter_if.sv | 42 ++++
 rtl/noc_output_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_noc_output_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_output_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_output_arbiter_if
//   Bundles the requester-side FIFO signals and the downstream output
//   handshake of one router output port.
//
//   Signals:
//     req_data     NUM_REQ*FLIT_W  head-of-FIFO flits, requester i at [i*FLIT_W +: FLIT_W]
//     req_empty    NUM_REQ         FIFO empty flags
//     req_read     NUM_REQ         one-cycle FIFO read strobes
//     output_data  FLIT_W          flit presented downstream (0 when not valid)
//     output_req   1               output_data is valid
//     output_bussy 1               downstream cannot accept this cycle
//     grant        NUM_REQ         one-hot owner of the output, 0 when idle
//     err_flit     1               pulse when a stray/illegal flit is discarded
//
//   Modports:
//     master  arbiter side
//     slave   FIFO / downstream environment side
// -----------------------------------------------------------------------------
interface noc_output_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned FLIT_W  = 16
);
    logic [NUM_REQ*FLIT_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_empty;
    logic [NUM_REQ-1:0]        req_read;
    logic [FLIT_W-1:0]         output_data;
    logic                      output_req;
    logic                      output_bussy;
    logic [NUM_REQ-1:0]        grant;
    logic                      err_flit;

    modport master (
        input  req_data, req_empty, output_bussy,
        output req_read, output_data, output_req, grant, err_flit
    );

    modport slave (
        output req_data, req_empty, output_bussy,
        input  req_read, output_data, output_req, grant, err_flit
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// noc_output_arbiter
//   Packet-level arbiter sharing one router output among NUM_REQ input FIFOs.
//   Priority heads (type 001) beat regular heads (type 000); round-robin from
//   rr_ptr within a class. The grant is held from head to tail so packets never
//   interleave. Stray non-head flits seen while idle are discarded with err_flit.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous active-high reset
//     bus   noc_output_arbiter_if.master (FIFO heads/empties/reads, output
//           req/bussy/data, grant, err_flit)
//
//   Parameters: NUM_REQ (1..8), FLIT_W (type = [FLIT_W-1:FLIT_W-3]), AGE_LIMIT
//
//   Optional feature: define ARB_AGING_EN to add per-requester age counters
//   that promote a starved regular requester to the priority class once its
//   count reaches AGE_LIMIT.
// -----------------------------------------------------------------------------
module noc_output_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned FLIT_W    = 16,
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_output_arbiter_if.master bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8 || AGE_LIMIT < 1) begin : g_bad_params
        $error("noc_output_arbiter: NUM_REQ or AGE_LIMIT out of range");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_gnt_idx;
    logic [PTR_W-1:0]   r_rr_ptr;

    logic [2:0]         w_type [NUM_REQ];
    logic [NUM_REQ-1:0] w_pri_vec;
    logic [NUM_REQ-1:0] w_reg_vec;
    logic [NUM_REQ-1:0] w_stray_vec;
    logic [NUM_REQ-1:0] w_stray_oh;
    logic [NUM_REQ-1:0] w_aged;
    logic [NUM_REQ-1:0] w_cand;
    logic               w_win_found;
    logic [PTR_W-1:0]   w_win_idx;
    logic [PTR_W-1:0]   w_scan;

    logic [FLIT_W-1:0]  w_gnt_flit;
    logic [2:0]         w_gnt_type;
    logic               w_valid;
    logic               w_xfer;
    logic               w_pkt_end;
    logic [PTR_W-1:0]   w_next_ptr;

    // Per-requester head classification.
    always_comb begin
        w_pri_vec   = '0;
        w_reg_vec   = '0;
        w_stray_vec = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_type[i]      = bus.req_data[i*FLIT_W + FLIT_W - 3 +: 3];
            w_pri_vec[i]   = !bus.req_empty[i] && (w_type[i] == 3'b001);
            w_reg_vec[i]   = !bus.req_empty[i] && (w_type[i] == 3'b000);
            w_stray_vec[i] = !bus.req_empty[i] && (w_type[i][2] || w_type[i][1]);
        end
    end

    // Isolate the lowest-index stray; only one discard per cycle.
    assign w_stray_oh = w_stray_vec & (~w_stray_vec + NUM_REQ'(1));

    // Aged regular requesters join the priority class.
    always_comb begin
        w_cand = ((w_pri_vec | w_aged) != '0) ? (w_pri_vec | w_aged) : w_reg_vec;
    end

    // First candidate at or above rr_ptr, wrapping.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_win_found && w_cand[w_scan]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan;
            end
        end
    end

    // Granted FIFO view. Reset suppresses transfers so the rest of an
    // interrupted packet stays in the FIFO.
    assign w_gnt_flit = bus.req_data[32'(r_gnt_idx)*FLIT_W +: FLIT_W];
    assign w_gnt_type = w_gnt_flit[FLIT_W-1 -: 3];
    assign w_valid    = (r_state == SEND) && !bus.req_empty[r_gnt_idx] && !rst;
    assign w_xfer     = w_valid && !bus.output_bussy;
    // Illegal 1xx codes close the packet like a tail.
    assign w_pkt_end  = w_xfer && ((w_gnt_type == 3'b011) || w_gnt_type[2]);
    assign w_next_ptr = (r_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + PTR_W'(1);

    always_comb begin
        bus.grant       = r_grant;
        bus.output_req  = w_valid;
        bus.output_data = w_valid ? w_gnt_flit : '0;
        bus.req_read    = '0;
        bus.err_flit    = 1'b0;
        if (r_state == SEND) begin
            bus.req_read = w_xfer ? r_grant : '0;
            bus.err_flit = w_xfer && w_gnt_type[2];
        end else if (!rst) begin
            bus.req_read = w_stray_oh;
            bus.err_flit = (w_stray_vec != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_found) begin
                        r_state   <= SEND;
                        r_gnt_idx <= w_win_idx;
                        r_grant   <= NUM_REQ'(1) << w_win_idx;
                    end
                end
                SEND: begin
                    if (w_pkt_end) begin
                        r_state  <= IDLE;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef ARB_AGING_EN
    localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0] r_age [NUM_REQ];

    always_comb begin
        w_aged = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_aged[i] = w_reg_vec[i] && (r_age[i] == AGE_W'(AGE_LIMIT));
        end
    end

    // Counts arbitrations lost while holding an eligible regular head.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (rst) begin
                r_age[i] <= '0;
            end else if (r_state == IDLE && w_win_found) begin
                if (32'(w_win_idx) == i) begin
                    r_age[i] <= '0;
                end else if (w_reg_vec[i] && r_age[i] != AGE_W'(AGE_LIMIT)) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    assign w_aged = '0;
`endif

endmodule

// File: tb/tb_noc_output_arbiter.sv
// -----------------------------------------------------------------------------
// tb_noc_output_arbiter
//   Directed bench for noc_output_arbiter (NUM_REQ=4, FLIT_W=16, AGE_LIMIT=2).
//   Behavioural FIFOs feed the requester side; each cycle the outputs are
//   compared against hand-computed values. Aging expectations depend on
//   ARB_AGING_EN.
// -----------------------------------------------------------------------------
module tb_noc_output_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned FW = 16;

    localparam logic [2:0] RH = 3'b000;
    localparam logic [2:0] PH = 3'b001;
    localparam logic [2:0] BD = 3'b010;
    localparam logic [2:0] TL = 3'b011;

    logic clk = 1'b0;
    logic rst;
    logic bussy;
    logic fifo_clr;

    always #5 clk = ~clk;

    noc_output_arbiter_if #(.NUM_REQ(NR), .FLIT_W(FW)) bus ();

    noc_output_arbiter #(
        .NUM_REQ  (NR),
        .FLIT_W   (FW),
        .AGE_LIMIT(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural source FIFOs.
    logic [FW-1:0] fmem [NR][64];
    logic [5:0]    fwr  [NR];
    logic [5:0]    frd  [NR];

    assign bus.output_bussy = bussy;

    always_comb begin
        bus.req_empty = '0;
        bus.req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req_empty[i]       = (frd[i] == fwr[i]);
            bus.req_data[i*FW +: FW] = fmem[i][frd[i]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (fifo_clr)
                frd[i] <= '0;
            else if (bus.req_read[i])
                frd[i] <= frd[i] + 6'd1;
        end
    end

    int unsigned n_vec     = 0;
    int unsigned n_miscmp  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] fl(input logic [2:0] t, input logic [12:0] p);
        return {t, p};
    endfunction

    task automatic push(input int q, input logic [FW-1:0] f);
        fmem[q][fwr[q]] = f;
        fwr[q] = fwr[q] + 6'd1;
    endtask

    // Called at a falling edge with inputs already applied; checks and
    // advances to the next falling edge.
    task automatic expect_cycle(input string tag, input logic [3:0] g, input logic r,
                                input logic [FW-1:0] d, input logic [3:0] rd, input logic e);
        #1;
        check_val({tag, ".grant"}, 32'(bus.grant),       32'(g));
        check_val({tag, ".req"},   32'(bus.output_req),  32'(r));
        check_val({tag, ".data"},  32'(bus.output_data), 32'(d));
        check_val({tag, ".read"},  32'(bus.req_read),    32'(rd));
        check_val({tag, ".err"},   32'(bus.err_flit),    32'(e));
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        bussy    = 1'b0;
        fifo_clr = 1'b1;
        for (int q = 0; q < NR; q++) begin
            fwr[q] = '0;
            for (int j = 0; j < 64; j++) fmem[q][j] = '0;
        end
        repeat (3) @(negedge clk);
        expect_cycle("reset", 4'b0000, 1'b0, '0, 4'b0000, 1'b0);

        // Single 3-flit packet from req0.
        rst = 1'b0; fifo_clr = 1'b0;
        push(0, fl(RH, 13'h11)); push(0, fl(BD, 13'h12)); push(0, fl(TL, 13'h13));
        expect_cycle("t1.wait", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t1.head", 4'b0001, 1'b1, fl(RH, 13'h11), 4'b0001, 1'b0);
        expect_cycle("t1.body", 4'b0001, 1'b1, fl(BD, 13'h12), 4'b0001, 1'b0);
        expect_cycle("t1.tail", 4'b0001, 1'b1, fl(TL, 13'h13), 4'b0001, 1'b0);
        check_val("t1.pops", 32'(frd[0]), 32'd3);
        expect_cycle("t1.idle", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Round-robin between req1 and req2 (rr_ptr=1 after t1).
        push(1, fl(RH, 13'h21)); push(1, fl(TL, 13'h22));
        push(2, fl(RH, 13'h31)); push(2, fl(TL, 13'h32));
        expect_cycle("t2.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t2.h1",    4'b0010, 1'b1, fl(RH, 13'h21), 4'b0010, 1'b0);
        expect_cycle("t2.t1",    4'b0010, 1'b1, fl(TL, 13'h22), 4'b0010, 1'b0);
        push(1, fl(RH, 13'h23)); push(1, fl(TL, 13'h24));
        expect_cycle("t2.idle1", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t2.h2",    4'b0100, 1'b1, fl(RH, 13'h31), 4'b0100, 1'b0);
        expect_cycle("t2.t2",    4'b0100, 1'b1, fl(TL, 13'h32), 4'b0100, 1'b0);
        push(2, fl(RH, 13'h33)); push(2, fl(TL, 13'h34));
        expect_cycle("t2.idle2", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t2.h1b",   4'b0010, 1'b1, fl(RH, 13'h23), 4'b0010, 1'b0);
        expect_cycle("t2.t1b",   4'b0010, 1'b1, fl(TL, 13'h24), 4'b0010, 1'b0);
        expect_cycle("t2.idle3", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t2.h2b",   4'b0100, 1'b1, fl(RH, 13'h33), 4'b0100, 1'b0);
        expect_cycle("t2.t2b",   4'b0100, 1'b1, fl(TL, 13'h34), 4'b0100, 1'b0);
        expect_cycle("t2.idle4", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Priority head on req3 beats regular head on req0.
        push(3, fl(PH, 13'h41)); push(3, fl(TL, 13'h42));
        push(0, fl(RH, 13'h51)); push(0, fl(TL, 13'h52));
        expect_cycle("t3.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t3.ph",    4'b1000, 1'b1, fl(PH, 13'h41), 4'b1000, 1'b0);
        expect_cycle("t3.pt",    4'b1000, 1'b1, fl(TL, 13'h42), 4'b1000, 1'b0);
        expect_cycle("t3.gap",   4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t3.rh",    4'b0001, 1'b1, fl(RH, 13'h51), 4'b0001, 1'b0);
        expect_cycle("t3.rt",    4'b0001, 1'b1, fl(TL, 13'h52), 4'b0001, 1'b0);
        expect_cycle("t3.idle",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Backpressure for 5 cycles, then a FIFO underrun before the tail.
        push(0, fl(RH, 13'h61)); push(0, fl(BD, 13'h62)); push(0, fl(BD, 13'h63));
        expect_cycle("t4.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t4.head",  4'b0001, 1'b1, fl(RH, 13'h61), 4'b0001, 1'b0);
        bussy = 1'b1;
        for (int c = 0; c < 5; c++)
            expect_cycle("t4.busy", 4'b0001, 1'b1, fl(BD, 13'h62), 4'b0000, 1'b0);
        bussy = 1'b0;
        expect_cycle("t4.b1",    4'b0001, 1'b1, fl(BD, 13'h62), 4'b0001, 1'b0);
        expect_cycle("t4.b2",    4'b0001, 1'b1, fl(BD, 13'h63), 4'b0001, 1'b0);
        expect_cycle("t4.under", 4'b0001, 1'b0, '0,              4'b0000, 1'b0);
        push(0, fl(TL, 13'h64));
        expect_cycle("t4.tail",  4'b0001, 1'b1, fl(TL, 13'h64), 4'b0001, 1'b0);
        expect_cycle("t4.idle",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Stray flits in IDLE, alone and alongside a winner.
        push(2, fl(BD, 13'h71));
        expect_cycle("t5.stray", 4'b0000, 1'b0, '0,              4'b0100, 1'b1);
        expect_cycle("t5.clean", 4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        push(2, fl(3'b101, 13'h72)); push(3, fl(TL, 13'h73)); push(1, fl(RH, 13'h81));
        expect_cycle("t5.mix",   4'b0000, 1'b0, '0,              4'b0100, 1'b1);
        push(1, fl(TL, 13'h82));
        expect_cycle("t5.h",     4'b0010, 1'b1, fl(RH, 13'h81), 4'b0010, 1'b0);
        expect_cycle("t5.t",     4'b0010, 1'b1, fl(TL, 13'h82), 4'b0010, 1'b0);
        expect_cycle("t5.stray3",4'b0000, 1'b0, '0,              4'b1000, 1'b1);
        push(0, fl(RH, 13'h91)); push(0, fl(3'b110, 13'h92));
        expect_cycle("t5.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t5.ih",    4'b0001, 1'b1, fl(RH, 13'h91), 4'b0001, 1'b0);
        expect_cycle("t5.ill",   4'b0001, 1'b1, fl(3'b110, 13'h92), 4'b0001, 1'b1);
        expect_cycle("t5.idle",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Reset in the middle of a packet; leftovers become strays.
        push(0, fl(RH, 13'hA1)); push(0, fl(BD, 13'hA2)); push(0, fl(TL, 13'hA3));
        expect_cycle("t6.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t6.head",  4'b0001, 1'b1, fl(RH, 13'hA1), 4'b0001, 1'b0);
        rst = 1'b1;
        expect_cycle("t6.rst",   4'b0001, 1'b0, '0,              4'b0000, 1'b0);
        rst = 1'b0;
        expect_cycle("t6.s1",    4'b0000, 1'b0, '0,              4'b0001, 1'b1);
        expect_cycle("t6.s2",    4'b0000, 1'b0, '0,              4'b0001, 1'b1);
        expect_cycle("t6.idle",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);

        // Aging: req1 waits on a regular head while req0 sends priority packets.
        push(1, fl(RH, 13'hB1)); push(1, fl(TL, 13'hB2));
        push(0, fl(PH, 13'hC1)); push(0, fl(TL, 13'hC2));
        push(0, fl(PH, 13'hC3)); push(0, fl(TL, 13'hC4));
        push(0, fl(PH, 13'hC5)); push(0, fl(TL, 13'hC6));
        expect_cycle("t7.wait",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t7.p1h",   4'b0001, 1'b1, fl(PH, 13'hC1), 4'b0001, 1'b0);
        expect_cycle("t7.p1t",   4'b0001, 1'b1, fl(TL, 13'hC2), 4'b0001, 1'b0);
        expect_cycle("t7.gap1",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
        expect_cycle("t7.p2h",   4'b0001, 1'b1, fl(PH, 13'hC3), 4'b0001, 1'b0);
        expect_cycle("t7.p2t",   4'b0001, 1'b1, fl(TL, 13'hC4), 4'b0001, 1'b0);
        expect_cycle("t7.gap2",  4'b0000, 1'b0, '0,              4'b0000, 1'b0);
`ifdef ARB_AGING_EN
        expect_cycle("t7.aged_h", 4'b0010, 1'b1, fl(RH, 13'hB1), 4'b0010, 1'b0);
        expect_cycle("t7.aged_t", 4'b0010, 1'b1, fl(TL, 13'hB2), 4'b0010, 1'b0);
`else
        expect_cycle("t7.starve_h", 4'b0001, 1'b1, fl(PH, 13'hC5), 4'b0001, 1'b0);
        expect_cycle("t7.starve_t", 4'b0001, 1'b1, fl(TL, 13'hC6), 4'b0001, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
